// File: rtl/mem_block_ctrl.sv
// Block-transfer controller: buffers 128-bit L1 refill/writeback blocks and moves them as four
// 32-bit words over a ready-handshaked memory port. Optional macro: MEM_CRIT_WORD_FIRST_EN.
module mem_block_ctrl #(
  parameter int unsigned MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refill_req_i,
  input  logic [MEM_AW-1:0] refill_addr_i,
  input  logic              wb_req_i,
  input  logic [MEM_AW-1:0] wb_addr_i,
  input  logic [127:0]      blockout_i,
  output logic              busy_o,
  output logic              delivered_o,
  output logic [127:0]      blockin_o,
  output logic              wb_done_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {StIdle, StWb, StRd, StDone} state_e;

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [1:0]         rf_start_q;
  logic [MEM_AW-5:0]  wb_base_q;
  logic [MEM_AW-5:0]  rf_base_q;
  logic               rf_pend_q;
  logic [3:0][31:0]   buf_q;
  logic               busy_q;
  logic               delivered_q;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic [MEM_AW-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic [127:0]       blockin_q;

  logic [1:0]         cnt_nxt;
  logic [1:0]         req_start;
  logic [3:0][31:0]   fill_blk;
  logic               unused_addr_bits;

`ifdef MEM_CRIT_WORD_FIRST_EN
  assign req_start = refill_addr_i[3:2];
`else
  assign req_start = 2'd0;
`endif

  assign unused_addr_bits = ^{refill_addr_i[3:0], wb_addr_i[3:0]};

  always_comb begin
    cnt_nxt         = cnt_q + 2'd1;
    fill_blk        = buf_q;
    fill_blk[cnt_q] = mem_rdata_i;
  end

  // wb_done must coincide with the final write handshake, so it is decoded from live mem_ready.
  assign wb_done_o   = (state_q == StWb) && (cnt_q == 2'd3) && mem_ready_i;
  assign busy_o      = busy_q;
  assign delivered_o = delivered_q;
  assign blockin_o   = blockin_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      rf_start_q  <= 2'd0;
      wb_base_q   <= '0;
      rf_base_q   <= '0;
      rf_pend_q   <= 1'b0;
      buf_q       <= '0;
      busy_q      <= 1'b0;
      delivered_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      blockin_q   <= '0;
    end else begin
      delivered_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wb_req_i) begin
            wb_base_q   <= wb_addr_i[MEM_AW-1:4];
            buf_q       <= blockout_i;
            rf_pend_q   <= refill_req_i;
            rf_base_q   <= refill_addr_i[MEM_AW-1:4];
            rf_start_q  <= req_start;
            cnt_q       <= 2'd0;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= {wb_addr_i[MEM_AW-1:4], 4'h0};
            mem_wdata_q <= blockout_i[31:0];
            busy_q      <= 1'b1;
            state_q     <= StWb;
          end else if (refill_req_i) begin
            rf_base_q   <= refill_addr_i[MEM_AW-1:4];
            rf_start_q  <= req_start;
            cnt_q       <= req_start;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= {refill_addr_i[MEM_AW-1:4], req_start, 2'b00};
            busy_q      <= 1'b1;
            state_q     <= StRd;
          end
        end
        StWb: begin
          if (mem_ready_i) begin
            if (cnt_q == 2'd3) begin
              mem_wr_q <= 1'b0;
              if (rf_pend_q) begin
                rf_pend_q  <= 1'b0;
                cnt_q      <= rf_start_q;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {rf_base_q, rf_start_q, 2'b00};
                state_q    <= StRd;
              end else begin
                // wb_done already pulsed; nothing left to report, so release immediately.
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              cnt_q       <= cnt_nxt;
              mem_addr_q  <= {wb_base_q, cnt_nxt, 2'b00};
              mem_wdata_q <= buf_q[cnt_nxt];
            end
          end
        end
        StRd: begin
          if (mem_ready_i) begin
            buf_q[cnt_q] <= mem_rdata_i;
            if (cnt_nxt == rf_start_q) begin
              mem_rd_q    <= 1'b0;
              blockin_q   <= fill_blk;
              delivered_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              cnt_q      <= cnt_nxt;
              mem_addr_q <= {rf_base_q, cnt_nxt, 2'b00};
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_block_ctrl.md
# mem_block_ctrl

Block-transfer controller between the L1 data cache and the 32-bit main-memory port. It accepts single-cycle refill and writeback requests from L1 and buffers the 128-bit block. It serializes each block into four word transactions on a ready-handshaked memory bus. For refills it returns the assembled block with a one-cycle `delivered` pulse.

## Interface
- `MEM_AW`, 32: memory address width; block base = address with bits [3:0] cleared.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `refill_req`  in  1  single-cycle pulse: fetch block containing `refill_addr`.
- `refill_addr`  in  MEM_AW  miss address; [3:2] = requested word.
- `wb_req`  in  1  single-cycle pulse: write back the block on `blockout` to `wb_addr`.
- `wb_addr`  in  MEM_AW  victim block address.
- `blockout`  in  128  victim block from L1; word i = bits [32i+31:32i].
- `busy`  out  1  high from the cycle after acceptance until the cycle after the final pulse.
- `delivered`  out  1  one-cycle pulse: `blockin` valid.
- `blockin`  out  128  refilled block, same word packing; held until the next refill completes.
- `wb_done`  out  1  one-cycle pulse: all four victim words written.
- `mem_addr`  out  MEM_AW  word address (base + 4·word).
- `mem_rd`, `mem_wr`  out  1  read/write strobe; never both high.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  completes the current word transfer.

## Operation
- States: IDLE, WB, RD, DONE.
- IDLE:
  - Samples `refill_req`/`wb_req`. Requests arriving while `busy` are dropped; L1 must check `busy`.
  - On `wb_req`: latch `wb_addr` and `blockout` into internal buffer, go to WB.
  - On `refill_req` alone: latch `refill_addr`, go to RD.
  - On both in the same cycle: latch both, WB first, then RD without returning to IDLE.
- WB:
  - 2-bit word counter 0→3.
  - `mem_wr`=1, `mem_addr`=wb_base+4·cnt, `mem_wdata`=buffer word cnt.
  - Address and data held stable until `mem_ready`=1.
  - After word 3 handshake: pulse `wb_done`; go to RD if a refill is pending, else DONE.
- RD:
  - Counter starts at start word (see Configuration) and wraps 3→0.
  - `mem_rd`=1 held until `mem_ready`.
  - On each handshake, `mem_rdata` is written into buffer slot cnt.
  - After the fourth handshake, go to DONE.
- DONE (refill): copy buffer to `blockin`, pulse `delivered`, then IDLE.
- DONE (writeback only): go to IDLE; `wb_done` has already pulsed.
- Back-to-back words: after a handshake the strobe stays high and the address advances at the next edge. No bubble is inserted.
- `mem_ready` while no strobe is asserted is ignored.
- Word counter arithmetic is modulo 4; the address is computed as base | (cnt<<2). No carry into bit 4.

## Timing
- Reset values:
  - `busy`, `delivered`, `wb_done`, `mem_rd`, `mem_wr` = 0.
  - `mem_addr`, `mem_wdata`, `blockin` = 0.
  - State = IDLE, counter = 0, pending flags cleared.
- Reset mid-transfer aborts immediately: strobes are low the cycle after `rst`. No `delivered` or `wb_done` pulse. Partial buffer contents are discarded.
- Request accepted at edge N: strobe and address valid in cycle N+1.
- With `mem_ready` tied high:
  - Refill: strobe cycles N+1..N+4, `delivered` in cycle N+5.
  - Writeback: `wb_done` in cycle N+4.
  - Combined: writes N+1..N+4, reads N+5..N+8, `delivered` N+9.
- Each `mem_ready` wait cycle adds exactly one cycle.
- `busy` falls in the cycle after `delivered` or after the final `wb_done`.
- `blockin` changes only in the `delivered` cycle.

## Configuration
- `MEM_CRIT_WORD_FIRST_EN` defined: refill starts at word `refill_addr[3:2]` and wraps (e.g. 2,3,0,1).
- `MEM_CRIT_WORD_FIRST_EN` undefined: refill always fetches words 0,1,2,3.
- `blockin` packing and `delivered` timing are identical in both builds.
- Writeback order is always 0..3.

## Test plan
- Reset, then refill_req addr 0x0000_1040, mem_ready=1, memory word k = 0xA000_0000+k → mem_addr 0x1040,0x1044,0x1048,0x104C. `delivered` at N+5, `blockin`=0xA0000003_A0000002_A0000001_A0000000.
- wb_req addr 0x2000, blockout=0x44444444_33333333_22222222_11111111, mem_ready=1 → writes 0x11111111@0x2000 … 0x44444444@0x200C, `wb_done` at N+4, no `delivered`.
- wb_req + refill_req same cycle (wb 0x3000, refill 0x4008) → four writes to 0x3000.. then four reads from 0x4000 (or 0x4008 first when `MEM_CRIT_WORD_FIRST_EN` is defined), `delivered` at N+9.
- `mem_ready` low for 3 cycles on word 1 of a refill → `mem_addr`/`mem_rd` held stable for 4 cycles, `delivered` delayed 3 cycles to N+8.
- `MEM_CRIT_WORD_FIRST_EN` defined, refill addr 0x500C → address order 0x500C,0x5000,0x5004,0x5008. `blockin` packed by word index, not fetch order.
- rst asserted mid-refill after 2 words, refill_req pulsed while busy → strobes low next cycle, no `delivered`; request during busy dropped.
